cnn_frame_sched: RTL and testbench

Frame-level sequencer for the CNN pixel pipeline (window generator -> 3x3 conv -> RGB565 pack -> output DP-SRAM -> LCD controller).
- Starts and stops the window/conv pipeline, clears it between frames, and counts output-buffer writes to detect frame completion.
- Manages ping-pong output-buffer banks so the LCD always scans a complete frame while the next one is written.
- Supports single-shot and continuous modes, abort, and write-stall timeout detection.

---
 rtl/cnn_frame_sched.sv | 165 ++++++++++++++++
 tb/tb_cnn_frame_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_sched.sv
// Frame sequencer for the CNN pixel pipeline: clears and runs the window/conv
// path, counts output-buffer writes and flips the ping-pong banks at LCD vblank.
module cnn_frame_sched #(
  parameter int WIDTH     = 480,
  parameter int HEIGHT    = 272,
  parameter int OUT_PIX   = WIDTH * HEIGHT,
  parameter int CLR_TICKS = 4,
  parameter int TMO_TICKS = 65535,
  parameter int CNT_W     = 17
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEnClk,
  input  logic             iStart,
  input  logic             iCont,
  input  logic             iAbort,
  input  logic             iWrEn,
  input  logic             iLcdFrmStart,
  output logic             oPipeRun,
  output logic             oPipeClr,
  output logic             oWrBank,
  output logic             oRdBank,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr,
  output logic [7:0]       oFrmCnt,
  output logic [CNT_W-1:0] oPixCnt
);

  localparam int CLR_W = (CLR_TICKS > 1) ? $clog2(CLR_TICKS) : 1;
  localparam int TMO_W = (TMO_TICKS > 1) ? $clog2(TMO_TICKS) : 1;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(OUT_PIX - 1);
  localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_TICKS - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TMO_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SWAPWAIT,
    ERR
  } stateT;

  stateT            state;
  logic [CLR_W-1:0] clrCnt;
  logic [TMO_W-1:0] tmoCnt;
  logic             wrHit;

  // A write is only real when it lands on a pixel-rate tick.
  assign wrHit = iWrEn & iEnClk;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      oPipeRun <= 1'b0;
      oPipeClr <= 1'b0;
      oWrBank  <= 1'b0;
      oRdBank  <= 1'b1;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oErr     <= 1'b0;
      oFrmCnt  <= '0;
      oPixCnt  <= '0;
      clrCnt   <= '0;
      tmoCnt   <= '0;
    end else begin
      oDone <= 1'b0;
      if (iAbort) begin
        // Abort drops the frame in progress but keeps the bank pairing intact.
        state    <= IDLE;
        oPipeRun <= 1'b0;
        oPipeClr <= 1'b0;
        oBusy    <= 1'b0;
        oErr     <= 1'b0;
        oPixCnt  <= '0;
        clrCnt   <= '0;
        tmoCnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (iEnClk && (iStart || iCont)) begin
              state    <= CLEAR;
              oPipeClr <= 1'b1;
              oBusy    <= 1'b1;
              oPixCnt  <= '0;
              clrCnt   <= '0;
            end
          end

          CLEAR: begin
            if (iEnClk) begin
              if (clrCnt == LAST_CLR) begin
                state    <= RUN;
                oPipeClr <= 1'b0;
                oPipeRun <= 1'b1;
                tmoCnt   <= '0;
              end else begin
                clrCnt <= clrCnt + 1'b1;
              end
            end
          end

          RUN: begin
            if (wrHit) begin
              oPixCnt <= oPixCnt + 1'b1;
              tmoCnt  <= '0;
              if (oPixCnt == LAST_PIX) begin
                state    <= SWAPWAIT;
                oPipeRun <= 1'b0;
              end
            end else if (iEnClk) begin
              if (tmoCnt == LAST_TMO) begin
                state    <= ERR;
                oPipeRun <= 1'b0;
                oBusy    <= 1'b0;
                oErr     <= 1'b1;
              end else begin
                tmoCnt <= tmoCnt + 1'b1;
              end
            end
          end

          SWAPWAIT: begin
            // The LCD has just finished scanning: hand it the completed bank.
            if (iLcdFrmStart) begin
              oRdBank <= oWrBank;
              oWrBank <= ~oWrBank;
              oDone   <= 1'b1;
              oFrmCnt <= oFrmCnt + 1'b1;
              if (iCont) begin
                state    <= CLEAR;
                oPipeClr <= 1'b1;
                oPixCnt  <= '0;
                clrCnt   <= '0;
              end else begin
                state <= IDLE;
                oBusy <= 1'b0;
              end
            end
          end

          ERR: begin
            if (iEnClk && iStart) begin
              state    <= CLEAR;
              oErr     <= 1'b0;
              oPipeClr <= 1'b1;
              oBusy    <= 1'b1;
              oPixCnt  <= '0;
              clrCnt   <= '0;
            end
          end

          default: begin
            state    <= IDLE;
            oPipeRun <= 1'b0;
            oPipeClr <= 1'b0;
            oBusy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_frame_sched.sv
// Randomised and scenario-driven bench for cnn_frame_sched with a frame-level
// reference model tracking clear ticks left, write count and idle ticks.
module tb_cnn_frame_sched;

  localparam int OUT_PIX = 12;
  localparam int CLR_T   = 2;
  localparam int TMO_T   = 8;
  localparam int CNT_W   = 17;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic             iEnClk = 1'b0;
  logic             iStart = 1'b0;
  logic             iCont = 1'b0;
  logic             iAbort = 1'b0;
  logic             iWrEn = 1'b0;
  logic             iLcdFrmStart = 1'b0;
  logic             oPipeRun, oPipeClr, oWrBank, oRdBank, oBusy, oDone, oErr;
  logic [7:0]       oFrmCnt;
  logic [CNT_W-1:0] oPixCnt;

  int nVec = 0;
  int nBad = 0;

  // Reference model state
  int mClrLeft, mPix, mIdle, mFrm;
  bit mRun, mWait, mErr, mDone, mWr, mRd;

  cnn_frame_sched #(
    .WIDTH(4), .HEIGHT(3), .OUT_PIX(OUT_PIX), .CLR_TICKS(CLR_T),
    .TMO_TICKS(TMO_T), .CNT_W(CNT_W)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEnClk(iEnClk), .iStart(iStart), .iCont(iCont),
    .iAbort(iAbort), .iWrEn(iWrEn), .iLcdFrmStart(iLcdFrmStart),
    .oPipeRun(oPipeRun), .oPipeClr(oPipeClr), .oWrBank(oWrBank), .oRdBank(oRdBank),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oFrmCnt(oFrmCnt), .oPixCnt(oPixCnt)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mClrLeft = 0; mPix = 0; mIdle = 0; mFrm = 0;
    mRun = 0; mWait = 0; mErr = 0; mDone = 0; mWr = 0; mRd = 1;
  endtask

  task automatic startClear();
    mClrLeft = CLR_T;
    mPix = 0;
  endtask

  task automatic modelStep();
    bit tick;
    bit wr;
    tick = iEnClk;
    wr = iEnClk && iWrEn;
    mDone = 0;
    if (iAbort) begin
      mClrLeft = 0; mRun = 0; mWait = 0; mErr = 0; mPix = 0; mIdle = 0;
    end else if (mClrLeft > 0) begin
      if (tick) begin
        mClrLeft--;
        if (mClrLeft == 0) begin mRun = 1; mIdle = 0; end
      end
    end else if (mRun) begin
      if (wr) begin
        mPix++; mIdle = 0;
        if (mPix == OUT_PIX) begin mRun = 0; mWait = 1; end
      end else if (tick) begin
        mIdle++;
        if (mIdle == TMO_T) begin mRun = 0; mErr = 1; end
      end
    end else if (mWait) begin
      if (iLcdFrmStart) begin
        mRd = mWr; mWr = ~mWr; mDone = 1; mFrm = (mFrm + 1) % 256; mWait = 0;
        if (iCont) startClear();
      end
    end else if (mErr) begin
      if (tick && iStart) begin mErr = 0; startClear(); end
    end else if (tick && (iStart || iCont)) begin
      startClear();
    end
  endtask

  task automatic compareAll();
    checkVal("pipeRun", oPipeRun, mRun);
    checkVal("pipeClr", oPipeClr, mClrLeft > 0);
    checkVal("wrBank", oWrBank, mWr);
    checkVal("rdBank", oRdBank, mRd);
    checkVal("busy", oBusy, (mClrLeft > 0) || mRun || mWait);
    checkVal("done", oDone, mDone);
    checkVal("err", oErr, mErr);
    checkVal("frmCnt", oFrmCnt, mFrm);
    checkVal("pixCnt", oPixCnt, mPix);
  endtask

  task automatic cycle();
    @(posedge iClk);
    modelStep();
    #1;
    compareAll();
    iEnClk = ~iEnClk;
  endtask

  task automatic waitTicks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      if (iEnClk) t++;
      cycle();
    end
  endtask

  task automatic waitPix(input int target);
    int n;
    n = 0;
    while (mPix != target && n < 400) begin cycle(); n++; end
    checkVal("reachPix", oPixCnt, target);
  endtask

  task automatic waitSwap();
    int n;
    n = 0;
    while (!mWait && n < 400) begin cycle(); n++; end
    checkVal("reachSwapWait", {oBusy, oPipeRun, oPipeClr}, 3'b100);
  endtask

  task automatic applyReset();
    iRst = 1; iStart = 0; iCont = 0; iAbort = 0; iWrEn = 0; iLcdFrmStart = 0;
    @(posedge iClk);
    #1;
    modelReset();
    compareAll();
    iRst = 0;
  endtask

  initial begin
    int wrRate;
    modelReset();
    applyReset();

    // Single shot
    iWrEn = 1; iStart = 1; waitTicks(1); iStart = 0;
    waitSwap();
    checkVal("t1Pix", oPixCnt, 12);
    iWrEn = 0; cycle(); cycle();
    iLcdFrmStart = 1; cycle(); iLcdFrmStart = 0;
    checkVal("t1Done", oDone, 1);
    cycle();
    checkVal("t1DoneOnce", oDone, 0);
    checkVal("t1WrBank", oWrBank, 1);
    checkVal("t1RdBank", oRdBank, 0);
    checkVal("t1FrmCnt", oFrmCnt, 1);
    checkVal("t1Busy", oBusy, 0);

    // Continuous
    applyReset();
    iCont = 1; iWrEn = 1;
    for (int f = 0; f < 3; f++) begin
      waitSwap();
      iLcdFrmStart = 1; cycle(); iLcdFrmStart = 0;
      checkVal("t2WrBank", oWrBank, (f % 2 == 0) ? 1 : 0);
      checkVal("t2ReClear", oPipeClr, 1);
      checkVal("t2FrmCnt", oFrmCnt, f + 1);
    end

    // Timeout
    applyReset();
    iWrEn = 1; iStart = 1; waitTicks(1); iStart = 0;
    waitPix(5);
    iWrEn = 0;
    waitTicks(TMO_T);
    checkVal("t3Err", oErr, 1);
    checkVal("t3Run", oPipeRun, 0);
    checkVal("t3Pix", oPixCnt, 5);
    checkVal("t3WrBank", oWrBank, 0);
    checkVal("t3RdBank", oRdBank, 1);
    iCont = 1; waitTicks(3); iCont = 0;
    checkVal("t3ContNoExit", oErr, 1);
    iStart = 1; waitTicks(1); iStart = 0;
    checkVal("t3ErrClr", oErr, 0);
    checkVal("t3Clear", oPipeClr, 1);

    // Abort
    applyReset();
    iWrEn = 1; iStart = 1; waitTicks(1); iStart = 0;
    waitPix(7);
    iAbort = 1; cycle(); iAbort = 0;
    checkVal("t4Pix", oPixCnt, 0);
    checkVal("t4Run", oPipeRun, 0);
    checkVal("t4Done", oDone, 0);
    checkVal("t4Busy", oBusy, 0);
    checkVal("t4FrmCnt", oFrmCnt, 0);
    iAbort = 1; iStart = 1; waitTicks(3);
    checkVal("t4AbortWins", oBusy, 0);
    checkVal("t4NoClear", oPipeClr, 0);
    iAbort = 0; iStart = 0;

    // Last write coincides with vblank
    applyReset();
    iWrEn = 1; iStart = 1; waitTicks(1); iStart = 0;
    waitPix(11);
    if (!iEnClk) cycle();
    iLcdFrmStart = 1; cycle(); iLcdFrmStart = 0;
    checkVal("t5Pix", oPixCnt, 12);
    checkVal("t5NoDone", oDone, 0);
    checkVal("t5NoSwap", oWrBank, 0);
    waitTicks(2);
    checkVal("t5PixHeld", oPixCnt, 12);
    iWrEn = 0;
    iLcdFrmStart = 1; cycle(); iLcdFrmStart = 0;
    checkVal("t5Done", oDone, 1);
    checkVal("t5WrBank", oWrBank, 1);
    checkVal("t5RdBank", oRdBank, 0);

    // Asynchronous reset mid-run
    iWrEn = 1; iStart = 1; waitTicks(1); iStart = 0;
    waitPix(3);
    #2;
    iRst = 1;
    #1;
    checkVal("t6Run", oPipeRun, 0);
    checkVal("t6Clr", oPipeClr, 0);
    checkVal("t6WrBank", oWrBank, 0);
    checkVal("t6RdBank", oRdBank, 1);
    checkVal("t6Busy", oBusy, 0);
    checkVal("t6Err", oErr, 0);
    checkVal("t6FrmCnt", oFrmCnt, 0);
    checkVal("t6Pix", oPixCnt, 0);
    modelReset();
    iWrEn = 0;
    @(posedge iClk);
    #1;
    iRst = 0;
    compareAll();

    // Random traffic
    wrRate = 8;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: wrRate = 0;
          1: wrRate = 3;
          2: wrRate = 8;
          default: wrRate = 10;
        endcase
      end
      if ($urandom_range(0, 99) == 0) iCont = ~iCont;
      iStart = ($urandom_range(0, 7) == 0);
      iAbort = ($urandom_range(0, 199) == 0);
      iWrEn = ($urandom_range(0, 9) < wrRate);
      iLcdFrmStart = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
